cache_refill_responder: RTL and testbench
=========================================

Name: cache_refill_responder

Overview:
- Main-memory side of the data-cache miss interface. It is the responder the cache controller talks to when the core stalls on `miss`.
- Accepts one line-granular request at a time:
  - Read (refill): after a fixed access latency, returns the line as a burst of 32-bit beats.
  - Write (writeback): collects the line beat-by-beat, then signals completion after the same latency.
- Holds the backing word array. Array contents survive reset.

Parameters:
- ADDR_LEN, 12, word-address width of backing memory (2^ADDR_LEN words).
- LINE_ADDR_LEN, 3, log2 words per line (line = 8 words).
- MEM_LATENCY, 50, access delay in cycles; legal range 1..1023.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = writeback, 0 = refill; sampled on accept
- req_line_addr  in  ADDR_LEN-LINE_ADDR_LEN  line address; sampled on accept
- wr_data  in  32  writeback beat
- wr_data_valid  in  1  writeback beat present
- wr_data_ready  out  1  responder takes beat this cycle
- rd_data  out  32  refill beat (registered)
- rd_data_valid  out  1  rd_data valid this cycle
- rd_data_last  out  1  final beat of refill burst
- wr_done  out  1  one-cycle pulse, writeback complete
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous and active-high.
- Reset values: state = IDLE, beat_cnt = 0, lat_cnt = 0; rd_data = 0, rd_data_valid = 0, rd_data_last = 0, wr_done = 0, wr_data_ready = 0, busy = 0.
  - req_ready is 0 while rst is high.
  - The memory array is not cleared.
- N = 2^LINE_ADDR_LEN. Word address = {line_addr_q, beat_cnt}. beat_cnt is LINE_ADDR_LEN bits and wraps naturally at N.
- Handshake:
  - A request is accepted on the edge where req_valid & req_ready; line address and req_write are latched there.
  - req_ready = (state == IDLE) & ~rst.
  - req_valid in any other state is ignored; the requester holds it.
  - A write beat transfers on the edge where wr_data_valid & wr_data_ready.
- States:
  - IDLE: wait for accept. On a write go to WR_BEATS; on a read go to WAIT with lat_cnt = MEM_LATENCY-1.
  - WR_BEATS: wr_data_ready = 1. Each transferred beat is written to mem[{line, beat_cnt}] and beat_cnt increments. On the Nth beat go to WAIT with lat_cnt = MEM_LATENCY-1 and beat_cnt = 0. Gaps (wr_data_valid low) stall indefinitely.
  - WAIT: lat_cnt decrements each cycle. When lat_cnt == 0:
    - Read: go to RD_BURST.
    - Write: go to WR_DONE.
  - RD_BURST: each cycle drive mem[{line, beat_cnt}] with rd_data_valid = 1, then increment beat_cnt. rd_data_last = 1 on beat N-1. After the last beat return to IDLE, beat_cnt = 0. The cache never backpressures reads.
  - WR_DONE: wr_done = 1 for exactly one cycle, then IDLE.
- Timing with accept at edge k:
  - Read: WAIT occupies cycles k+1..k+MEM_LATENCY; beats appear in cycles k+MEM_LATENCY+1 .. k+MEM_LATENCY+N; req_ready is high again in cycle k+MEM_LATENCY+N+1.
  - Write: last beat transferred at edge j, then WAIT occupies j+1..j+MEM_LATENCY and wr_done is high in cycle j+MEM_LATENCY+1.
- rd_data is registered from a synchronous array read; the read is issued one cycle ahead, so no bubble occurs between beats.
- wr_data_valid outside WR_BEATS is ignored; no write occurs.
- Back-to-back requests: a request may be accepted in the cycle after the last refill beat or after the wr_done pulse.
- Reset mid-operation:
  - Any state returns to IDLE next edge and the in-flight transaction is dropped.
  - Writeback beats already written stay in the array (partial line).
  - No rd_data_valid or wr_done is emitted after reset asserts.
- Read-after-write to the same line returns the newly written data.

Decomposition:
- Shared package `cache_mem_pkg`:
  - state encoding localparams (IDLE, WR_BEATS, WAIT, RD_BURST, WR_DONE);
  - LINE_ADDR_LEN default;
  - latency counter width (10 bits).
- One sub-module, `main_mem_array`: single-port synchronous RAM, 32-bit wide, 2^ADDR_LEN deep, with write enable, address and write data; registered read data; no reset.
- FSM, counters and handshake logic stay in the top block.

Test Plan:
- Refill: MEM_LATENCY=4, array preloaded mem[8..15] = 0x100..0x107, read req_line_addr=1 accepted at edge 0 -> req_ready low cycles 1..12; rd_data_valid high cycles 5..12 with 0x100..0x107; rd_data_last only in cycle 12; busy low in cycle 13.
- Writeback: write line 2 with beats 0xA0..0xA7, wr_data_valid deasserted for 3 cycles after beat 3 -> mem[16..23] = 0xA0..0xA7; beat_cnt holds during the gap; wr_done is a single pulse exactly 5 cycles after the last beat. A following read of line 2 returns 0xA0..0xA7.
- Request while busy: req_valid held high during a refill with a different address -> ignored until IDLE, then accepted; first burst data unchanged.
- Reset mid-burst: rst asserted at 3rd refill beat -> next cycle rd_data_valid = 0, busy = 0, req_ready = 1 after rst drops; a new read returns correct data.
- Reset mid-writeback after 4 beats of 0xFF -> mem[line*8 .. line*8+3] = 0xFF, remaining 4 words unchanged, no wr_done.
- Boundary: MEM_LATENCY=1 with the top line (all-ones line address) -> beats start 2 cycles after accept; addresses stay inside the array (no wrap into line 0).

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache refill responder: state codes, line geometry
// and counter widths.
package cache_mem_pkg;

  localparam int WORD_W            = 32;
  localparam int LINE_ADDR_LEN_DEF = 3;
  localparam int LAT_W             = 10;
  localparam int STATE_W           = 3;

  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_WR_BEATS = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT     = 3'd2;
  localparam logic [STATE_W-1:0] ST_RD_BURST = 3'd3;
  localparam logic [STATE_W-1:0] ST_WR_DONE  = 3'd4;

endpackage

// File: rtl/main_mem_array.sv
// Single-port synchronous word RAM backing the responder; read data is registered
// and the contents are never reset.
module main_mem_array
  import cache_mem_pkg::*;
#(
  parameter int ADDR_LEN = 12
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [ADDR_LEN-1:0] i_addr,
  input  logic [WORD_W-1:0]   i_wdata,
  output logic [WORD_W-1:0]   o_rdata
);

  logic [WORD_W-1:0] r_mem [0:(1<<ADDR_LEN)-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/cache_refill_responder.sv
// Memory-side responder for data-cache misses: serves line refills as bursts and
// absorbs line writebacks, each after a fixed access latency.
module cache_refill_responder
  import cache_mem_pkg::*;
#(
  parameter int ADDR_LEN      = 12,
  parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
  parameter int MEM_LATENCY   = 50
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [ADDR_LEN-LINE_ADDR_LEN-1:0] req_line_addr,
  input  logic [WORD_W-1:0]                 wr_data,
  input  logic                              wr_data_valid,
  output logic                              wr_data_ready,
  output logic [WORD_W-1:0]                 rd_data,
  output logic                              rd_data_valid,
  output logic                              rd_data_last,
  output logic                              wr_done,
  output logic                              busy
);

  localparam int                       LINE_W     = ADDR_LEN - LINE_ADDR_LEN;
  localparam logic [LAT_W-1:0]         LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);
  localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT  = '1;
  localparam logic [LINE_ADDR_LEN-1:0] BEAT_ONE   = LINE_ADDR_LEN'(1);
  localparam logic [LAT_W-1:0]         LAT_ONE    = LAT_W'(1);

  logic [STATE_W-1:0]       r_state;
  logic [LINE_ADDR_LEN-1:0] r_beat_cnt;
  logic [LAT_W-1:0]         r_lat_cnt;
  logic [LINE_W-1:0]        r_line;
  logic                     r_write;

  logic                     w_accept;
  logic                     w_wr_beat;
  logic                     w_rd_active;
  logic [LINE_ADDR_LEN-1:0] w_beat_sel;
  logic [ADDR_LEN-1:0]      w_mem_addr;
  logic [WORD_W-1:0]        w_mem_q;

  assign req_ready     = (r_state == ST_IDLE) & ~rst;
  assign w_accept      = req_valid & req_ready;
  assign wr_data_ready = (r_state == ST_WR_BEATS) & ~rst;
  assign w_wr_beat     = wr_data_valid & wr_data_ready;
  assign w_rd_active   = (r_state == ST_RD_BURST) & ~rst;
  assign busy          = (r_state != ST_IDLE);
  assign rd_data_valid = w_rd_active;
  assign rd_data_last  = w_rd_active & (r_beat_cnt == LAST_BEAT);
  assign rd_data       = w_rd_active ? w_mem_q : '0;
  assign wr_done       = (r_state == ST_WR_DONE) & ~rst;

  // During a burst the RAM is addressed one beat ahead so its registered output
  // lines up with beat_cnt; the last-beat lookahead wraps within the same line.
  assign w_beat_sel = (r_state == ST_RD_BURST) ? r_beat_cnt + BEAT_ONE : r_beat_cnt;
  assign w_mem_addr = {r_line, w_beat_sel};

  main_mem_array #(
    .ADDR_LEN (ADDR_LEN)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_beat),
    .i_addr  (w_mem_addr),
    .i_wdata (wr_data),
    .o_rdata (w_mem_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_beat_cnt <= '0;
      r_lat_cnt  <= '0;
      r_line     <= '0;
      r_write    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_line     <= req_line_addr;
            r_write    <= req_write;
            r_beat_cnt <= '0;
            if (req_write) begin
              r_state <= ST_WR_BEATS;
            end else begin
              r_state   <= ST_WAIT;
              r_lat_cnt <= LAT_RELOAD;
            end
          end
        end
        ST_WR_BEATS: begin
          if (w_wr_beat) begin
            r_beat_cnt <= r_beat_cnt + BEAT_ONE;
            if (r_beat_cnt == LAST_BEAT) begin
              r_state   <= ST_WAIT;
              r_lat_cnt <= LAT_RELOAD;
            end
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_state <= r_write ? ST_WR_DONE : ST_RD_BURST;
          end else begin
            r_lat_cnt <= r_lat_cnt - LAT_ONE;
          end
        end
        ST_RD_BURST: begin
          r_beat_cnt <= r_beat_cnt + BEAT_ONE;
          if (r_beat_cnt == LAST_BEAT) begin
            r_state <= ST_IDLE;
          end
        end
        ST_WR_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_responder.sv
// Directed bench for cache_refill_responder: a latency-4 instance for the main
// scenarios and a latency-1 instance for the top-line boundary case.
module tb_cache_refill_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqWrite;
  logic [8:0]  reqLineAddr;
  logic [31:0] wrData;
  logic        wrDataValid;
  logic        sel;

  logic        reqReadyA, wrReadyA, rdValidA, rdLastA, wrDoneA, busyA;
  logic [31:0] rdDataA;
  logic        reqReadyB, wrReadyB, rdValidB, rdLastB, wrDoneB, busyB;
  logic [31:0] rdDataB;

  logic        obsReqReady, obsWrReady, obsRdValid, obsRdLast, obsWrDone, obsBusy;
  logic [31:0] obsRdData;

  int errCount   = 0;
  int checkCount = 0;

  logic [31:0] dLine1 [8];
  logic [31:0] dLineA [8];
  logic [31:0] dLine3 [8];
  logic [31:0] dLine3Mix [8];
  logic [31:0] dTop [8];
  logic [31:0] dZero [8];

  always #5 clk = ~clk;

  cache_refill_responder #(
    .ADDR_LEN      (12),
    .LINE_ADDR_LEN (3),
    .MEM_LATENCY   (4)
  ) dutA (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (reqValid & ~sel),
    .req_ready     (reqReadyA),
    .req_write     (reqWrite),
    .req_line_addr (reqLineAddr),
    .wr_data       (wrData),
    .wr_data_valid (wrDataValid & ~sel),
    .wr_data_ready (wrReadyA),
    .rd_data       (rdDataA),
    .rd_data_valid (rdValidA),
    .rd_data_last  (rdLastA),
    .wr_done       (wrDoneA),
    .busy          (busyA)
  );

  cache_refill_responder #(
    .ADDR_LEN      (12),
    .LINE_ADDR_LEN (3),
    .MEM_LATENCY   (1)
  ) dutB (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (reqValid & sel),
    .req_ready     (reqReadyB),
    .req_write     (reqWrite),
    .req_line_addr (reqLineAddr),
    .wr_data       (wrData),
    .wr_data_valid (wrDataValid & sel),
    .wr_data_ready (wrReadyB),
    .rd_data       (rdDataB),
    .rd_data_valid (rdValidB),
    .rd_data_last  (rdLastB),
    .wr_done       (wrDoneB),
    .busy          (busyB)
  );

  assign obsReqReady = sel ? reqReadyB : reqReadyA;
  assign obsWrReady  = sel ? wrReadyB  : wrReadyA;
  assign obsRdValid  = sel ? rdValidB  : rdValidA;
  assign obsRdLast   = sel ? rdLastB   : rdLastA;
  assign obsWrDone   = sel ? wrDoneB   : wrDoneA;
  assign obsBusy     = sel ? busyB     : busyA;
  assign obsRdData   = sel ? rdDataB   : rdDataA;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises a request and returns one cycle after the accepting edge.
  task automatic applyStimulus(input logic isWrite, input logic [8:0] line);
    int guard = 0;
    reqWrite    = isWrite;
    reqLineAddr = line;
    reqValid    = 1'b1;
    while (obsReqReady !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    checkOutput("acceptReady", 32'(obsReqReady), 32'd1);
    tick();
    reqValid = 1'b0;
  endtask

  task automatic checkBurst(input logic [31:0] expData [8], input int lat);
    checkOutput("busyAfterAccept", 32'(obsBusy), 32'd1);
    for (int c = 0; c < lat; c++) begin
      checkOutput("waitNoValid", 32'(obsRdValid), 32'd0);
      checkOutput("waitReqReady", 32'(obsReqReady), 32'd0);
      tick();
    end
    for (int b = 0; b < 8; b++) begin
      checkOutput("beatValid", 32'(obsRdValid), 32'd1);
      checkOutput("beatData", obsRdData, expData[b]);
      checkOutput("beatLast", 32'(obsRdLast), 32'(b == 7));
      checkOutput("beatReqReady", 32'(obsReqReady), 32'd0);
      tick();
    end
    checkOutput("endNoValid", 32'(obsRdValid), 32'd0);
    checkOutput("endBusy", 32'(obsBusy), 32'd0);
    checkOutput("endReqReady", 32'(obsReqReady), 32'd1);
  endtask

  task automatic writeLine(input logic [8:0] line, input logic [31:0] data [8],
                           input int gapAfter, input int gapLen, input int lat);
    applyStimulus(1'b1, line);
    for (int b = 0; b < 8; b++) begin
      checkOutput("wrReady", 32'(obsWrReady), 32'd1);
      wrData      = data[b];
      wrDataValid = 1'b1;
      tick();
      wrDataValid = 1'b0;
      if (b == gapAfter) begin
        for (int g = 0; g < gapLen; g++) begin
          checkOutput("gapReady", 32'(obsWrReady), 32'd1);
          checkOutput("gapNoDone", 32'(obsWrDone), 32'd0);
          tick();
        end
      end
    end
    for (int c = 0; c < lat; c++) begin
      checkOutput("wrWaitNoDone", 32'(obsWrDone), 32'd0);
      checkOutput("wrWaitNotReady", 32'(obsWrReady), 32'd0);
      tick();
    end
    checkOutput("wrDonePulse", 32'(obsWrDone), 32'd1);
    tick();
    checkOutput("wrDoneOnce", 32'(obsWrDone), 32'd0);
    checkOutput("wrIdleReady", 32'(obsReqReady), 32'd1);
  endtask

  // Bounds the whole run in case the design never hands back control.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checkCount, errCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      dLine1[i]    = 32'h100 + 32'(i);
      dLineA[i]    = 32'hA0 + 32'(i);
      dLine3[i]    = 32'h300 + 32'(i);
      dLine3Mix[i] = (i < 4) ? 32'hFF : 32'h300 + 32'(i);
      dTop[i]      = 32'h500 + 32'(i);
      dZero[i]     = 32'h600 + 32'(i);
    end
    rst         = 1'b1;
    reqValid    = 1'b0;
    reqWrite    = 1'b0;
    reqLineAddr = '0;
    wrData      = '0;
    wrDataValid = 1'b0;
    sel         = 1'b0;
    repeat (3) tick();

    checkOutput("rstReqReady", 32'(obsReqReady), 32'd0);
    checkOutput("rstBusy", 32'(obsBusy), 32'd0);
    checkOutput("rstRdValid", 32'(obsRdValid), 32'd0);
    checkOutput("rstRdLast", 32'(obsRdLast), 32'd0);
    checkOutput("rstRdData", obsRdData, 32'd0);
    checkOutput("rstWrDone", 32'(obsWrDone), 32'd0);
    checkOutput("rstWrReady", 32'(obsWrReady), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("postRstReady", 32'(obsReqReady), 32'd1);

    // Preload line 1, then refill it
    writeLine(9'd1, dLine1, 8, 0, 4);
    applyStimulus(1'b0, 9'd1);
    checkBurst(dLine1, 4);

    // Writeback with a three-cycle gap after beat 3, then read it back
    writeLine(9'd2, dLineA, 3, 3, 4);
    applyStimulus(1'b0, 9'd2);
    checkBurst(dLineA, 4);

    // A second request held through a refill is only taken once idle
    applyStimulus(1'b0, 9'd1);
    reqLineAddr = 9'd2;
    reqValid    = 1'b1;
    checkBurst(dLine1, 4);
    tick();
    reqValid = 1'b0;
    checkBurst(dLineA, 4);

    // Reset during the third refill beat
    applyStimulus(1'b0, 9'd1);
    repeat (6) tick();
    checkOutput("midBurstData", obsRdData, 32'h102);
    rst = 1'b1;
    tick();
    checkOutput("rstBurstValid", 32'(obsRdValid), 32'd0);
    checkOutput("rstBurstBusy", 32'(obsBusy), 32'd0);
    checkOutput("rstBurstReady", 32'(obsReqReady), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstBurstReadyAfter", 32'(obsReqReady), 32'd1);
    for (int c = 0; c < 12; c++) begin
      checkOutput("rstBurstSilent", 32'(obsRdValid), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 9'd1);
    checkBurst(dLine1, 4);

    // Reset after four writeback beats leaves a partial line
    writeLine(9'd3, dLine3, 8, 0, 4);
    applyStimulus(1'b1, 9'd3);
    for (int b = 0; b < 4; b++) begin
      wrData      = 32'hFF;
      wrDataValid = 1'b1;
      tick();
    end
    wrDataValid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstWrBusy", 32'(obsBusy), 32'd0);
    for (int c = 0; c < 10; c++) begin
      checkOutput("rstWrNoDone", 32'(obsWrDone), 32'd0);
      tick();
    end
    applyStimulus(1'b0, 9'd3);
    checkBurst(dLine3Mix, 4);

    // Latency 1 on the top line must not wrap into line 0
    sel = 1'b1;
    #1;
    writeLine(9'd0, dZero, 8, 0, 1);
    writeLine(9'h1FF, dTop, 8, 0, 1);
    applyStimulus(1'b0, 9'h1FF);
    checkBurst(dTop, 1);
    applyStimulus(1'b0, 9'd0);
    checkBurst(dZero, 1);

    $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
